// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves EXE branches against the fetch prediction,
// sequences flush/redirect on mispredict, and queues predictor training.
// Ports: clk/rst, ex_* (resolving branch in), ex_stall (update FIFO full),
//   redirect_valid/redirect_pc (fetch PC load), flush (squash young insts),
//   upd_* (training FIFO head, valid/ready handshake to predictor).
// Optional: define BR_RESOLVE_STATS_EN to add stat_branches/stat_mispredicts.
module branch_resolve_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        ex_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic        upd_btb_alloc
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state;
    logic [2:0]    fcnt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic [31:0] mem_pc  [QDEPTH];
    logic [31:0] mem_tgt [QDEPTH];
    logic        mem_tk  [QDEPTH];
    logic        mem_al  [QDEPTH];

    logic        accept;
    logic        mispred;
    logic        pop;
    logic [31:0] next_pc;

    assign ex_stall  = (count == CW'(QDEPTH));
    assign upd_valid = (count != '0);
    assign accept    = ex_valid & ~ex_stall & (state == RUN);
    assign pop       = upd_valid & upd_ready;

    // Target only matters when both prediction and outcome are taken.
    assign mispred = (ex_pred_taken != ex_taken)
                   | (ex_pred_taken & ex_taken & (ex_pred_target != ex_target));

    assign next_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

    // Head is read straight out of storage so it holds while stalled.
    assign upd_pc        = mem_pc[rptr];
    assign upd_target    = mem_tgt[rptr];
    assign upd_taken     = mem_tk[rptr];
    assign upd_btb_alloc = mem_al[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            fcnt           <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            unique case (state)
                RUN: begin
                    if (accept && mispred) begin
                        state          <= FLUSH;
                        fcnt           <= 3'(FLUSH_CYCLES - 1);
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= next_pc;
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end else begin
                        fcnt <= fcnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_pc[i]  <= '0;
                mem_tgt[i] <= '0;
                mem_tk[i]  <= 1'b0;
                mem_al[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                mem_pc[wptr]  <= ex_pc;
                mem_tgt[wptr] <= ex_target;
                mem_tk[wptr]  <= ex_taken;
                mem_al[wptr]  <= ex_taken & ~ex_pred_taken;
                wptr          <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (!accept && pop) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispred) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: scoreboard bench for branch_resolve_ctrl.
// Stimulus pushes expected updates/redirects; a negedge monitor pops them.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_btb_alloc;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_ctrl #(.QDEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_stall       (ex_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_btb_alloc  (upd_btb_alloc)
`ifdef BR_RESOLVE_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        logic        al;
    } ent_t;

    ent_t        uq[$];
    logic [31:0] rq[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptg, input logic tk,
                         input logic [31:0] tg);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        ex_taken       = tk;
        ex_target      = tg;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic pt,
                               input logic [31:0] ptg, input logic tk,
                               input logic [31:0] tg);
        ent_t e;
        e.pc = pc;
        e.tg = tg;
        e.tk = tk;
        e.al = tk & ~pt;
        uq.push_back(e);
        if (pt != tk || (pt && tk && ptg != tg))
            rq.push_back(tk ? tg : pc + 32'd4);
    endtask

    task automatic send(input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptg, input logic tk,
                        input logic [31:0] tg);
        expect_push(pc, pt, ptg, tk, tg);
        drive(pc, pt, ptg, tk, tg);
        step();
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!upd_valid && uq.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(uq.size()), 32'd0);
    endtask

    // Monitor: compares every handshake and every redirect pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid && upd_ready) begin
                if (uq.size() == 0) begin
                    check("unexpected_upd", upd_pc, 32'hxxxxxxxx);
                end else begin
                    ent_t e;
                    e = uq.pop_front();
                    check("upd_pc", upd_pc, e.pc);
                    check("upd_target", upd_target, e.tg);
                    check("upd_taken", 32'(upd_taken), 32'(e.tk));
                    check("upd_alloc", 32'(upd_btb_alloc), 32'(e.al));
                end
            end
            if (redirect_valid) begin
                if (rq.size() == 0)
                    check("unexpected_redirect", redirect_pc, 32'hxxxxxxxx);
                else
                    check("redirect_pc_sb", redirect_pc, rq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        ex_valid  = 1'b0;
        ex_pc     = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        ex_taken  = 1'b0;
        ex_target = '0;
        upd_ready = 1'b1;

        @(negedge clk);
        check("rst_stall", 32'(ex_stall), 32'd0);
        check("rst_redir", 32'(redirect_valid), 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_uvalid", 32'(upd_valid), 32'd0);
        check("rst_upc", upd_pc, 32'd0);
        check("rst_utgt", upd_target, 32'd0);
        check("rst_utaken", 32'(upd_taken), 32'd0);
        check("rst_ualloc", 32'(upd_btb_alloc), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Correct prediction
        send(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        @(negedge clk);
        check("ok_uvalid", 32'(upd_valid), 32'd1);
        check("ok_redir", 32'(redirect_valid), 32'd0);
        check("ok_flush", 32'(flush), 32'd0);
        step();

        // Direction mispredict
        send(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        @(negedge clk);
        check("dir_redir", 32'(redirect_valid), 32'd1);
        check("dir_redir_pc", redirect_pc, 32'h80);
        check("dir_flush1", 32'(flush), 32'd1);
        step();
        @(negedge clk);
        check("dir_flush2", 32'(flush), 32'd1);
        check("dir_redir_off", 32'(redirect_valid), 32'd0);
        step();
        @(negedge clk);
        check("dir_flush_off", 32'(flush), 32'd0);

        // Not-taken mispredict with PC wrap
        send(32'hFFFFFFFC, 1'b1, 32'h10, 1'b0, 32'h1234);
        @(negedge clk);
        check("wrap_redir", 32'(redirect_valid), 32'd1);
        check("wrap_redir_pc", redirect_pc, 32'h0);
        step();
        step();
        @(negedge clk);
        check("wrap_flush_off", 32'(flush), 32'd0);
        step();
        drain();

        // Back-pressure fill and single-pop release
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h1000 + 32'(i * 4), 1'b1, 32'h2000, 1'b1, 32'h2000);
        expect_push(32'h1010, 1'b1, 32'h2000, 1'b1, 32'h2000);
        drive(32'h1010, 1'b1, 32'h2000, 1'b1, 32'h2000);
        upd_ready = 1'b1;
        @(negedge clk);
        check("bp_full", 32'(ex_stall), 32'd1);
        step();
        upd_ready = 1'b0;
        @(negedge clk);
        check("bp_drop", 32'(ex_stall), 32'd0);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        check("bp_refill", 32'(ex_stall), 32'd1);
        step();
        upd_ready = 1'b1;
        drain();

        // Back-to-back correct branches
        for (int i = 0; i < 6; i++)
            send(32'h3000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0);
        drain();

        // Mispredict during flush shadow is ignored
        send(32'h300, 1'b0, 32'h0, 1'b1, 32'h400);
        drive(32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
        step();
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        check("shadow_flush_off", 32'(flush), 32'd0);
        step();
        drain();
        check("shadow_no_redir", 32'(rq.size()), 32'd0);

        // Reset during flush
        upd_ready = 1'b0;
        step();
        send(32'h700, 1'b1, 32'h800, 1'b1, 32'h900);
        @(negedge clk);
        check("rstf_flush_pre", 32'(flush), 32'd1);
        check("rstf_uvalid_pre", 32'(upd_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstf_flush", 32'(flush), 32'd0);
        check("rstf_uvalid", 32'(upd_valid), 32'd0);
        uq.delete();
        rq.delete();
        step();
        rst = 1'b0;
        upd_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rstf_idle_uvalid", 32'(upd_valid), 32'd0);
        check("rstf_idle_flush", 32'(flush), 32'd0);
        step();

`ifdef BR_RESOLVE_STATS_EN
        send(32'h10, 1'b1, 32'h20, 1'b1, 32'h20);
        send(32'h14, 1'b1, 32'h20, 1'b1, 32'h30);
        step();
        step();
        send(32'h18, 1'b0, 32'h0, 1'b0, 32'h0);
        drain();
        check("stat_branches", stat_branches, 32'd3);
        check("stat_mispredicts", stat_mispredicts, 32'd1);
`endif

        check("end_uq_empty", 32'(uq.size()), 32'd0);
        check("end_rq_empty", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
